// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module : hazard_scoreboard_pkg
// Brief  : Shared types and helpers for the decode/issue hazard scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
package hazard_scoreboard_pkg;

   // Counter field is sized for the largest latency any configuration may use.
   localparam int SB_CNT_W = 8;

   typedef struct packed {
      logic                busy;
      logic                is_var;
      logic [SB_CNT_W-1:0] cnt;
   } sb_entry_t;

   localparam logic [SB_CNT_W-1:0] SB_LAT_VAR    = '0;
   localparam sb_entry_t           SB_ENTRY_IDLE = '0;

   // cnt holds the cycles still visible as busy; latency 1 is forwardable next cycle.
   function automatic sb_entry_t sb_fixed_entry(input logic [SB_CNT_W-1:0] lat);
      sb_entry_t e;
      e.busy   = (lat > SB_CNT_W'(1));
      e.is_var = 1'b0;
      e.cnt    = lat - SB_CNT_W'(1);
      return e;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module : hazard_scoreboard_if
// Brief  : Decode-to-scoreboard issue handshake bundle.
// Rev    : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
   parameter int NUM_REGS = 32,
   parameter int NUM_SRC  = 2,
   parameter int MAX_LAT  = 7,
   parameter int REG_W    = $clog2(NUM_REGS),
   parameter int LAT_W    = $clog2(MAX_LAT + 1)
);
   logic                     issue_valid;
   logic                     issue_ready;
   logic [NUM_SRC*REG_W-1:0] issue_rs;
   logic [NUM_SRC-1:0]       issue_rs_read;
   logic [REG_W-1:0]         issue_rd;
   logic                     issue_rd_write;
   logic [LAT_W-1:0]         issue_lat;

   modport master (
      output issue_valid, issue_rs, issue_rs_read, issue_rd, issue_rd_write, issue_lat,
      input  issue_ready
   );

   modport slave (
      input  issue_valid, issue_rs, issue_rs_read, issue_rd, issue_rd_write, issue_lat,
      output issue_ready
   );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard_sb_entry.sv
`default_nettype none
// ============================================================================
// Module : sb_entry
// Brief  : Pending-write tracker for one architectural register.
// Rev    : 1.0 - initial release
// ============================================================================
module sb_entry
   import hazard_scoreboard_pkg::*;
#(
   parameter int LAT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             set,
   input  logic [LAT_W-1:0] set_lat,
   input  logic             var_clr,
   input  logic             flush,
   output logic             busy,
   output logic             is_var
);
   sb_entry_t           entry_q;
   sb_entry_t           entry_d;
   logic [SB_CNT_W-1:0] lat_ext;

   assign lat_ext = SB_CNT_W'(set_lat);

   always_comb begin
      entry_d = entry_q;
      if (entry_q.busy && !entry_q.is_var) begin
         if (entry_q.cnt <= SB_CNT_W'(1)) entry_d = SB_ENTRY_IDLE;
         else                             entry_d.cnt = entry_q.cnt - SB_CNT_W'(1);
      end
      if (var_clr && entry_q.busy && entry_q.is_var) entry_d = SB_ENTRY_IDLE;
      // Variable entries survive a flush: their unit has already accepted the op.
      if (flush && !entry_q.is_var) entry_d = SB_ENTRY_IDLE;
      if (set && !flush) begin
         if (lat_ext == SB_LAT_VAR) begin
            entry_d.busy   = 1'b1;
            entry_d.is_var = 1'b1;
            entry_d.cnt    = '0;
         end else begin
            entry_d = sb_fixed_entry(lat_ext);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) entry_q <= SB_ENTRY_IDLE;
      else     entry_q <= entry_d;
   end

   assign busy   = entry_q.busy;
   assign is_var = entry_q.is_var;
endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : hazard_scoreboard
// Brief  : Issue interlock tracking fixed- and variable-latency register writes.
// Rev    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int NUM_REGS = 32,
   parameter int REG_W    = $clog2(NUM_REGS),
   parameter int NUM_SRC  = 2,
   parameter int MAX_LAT  = 7,
   parameter int LAT_W    = $clog2(MAX_LAT + 1),
   parameter int CNT_W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   hazard_scoreboard_if.slave  iss,
   input  logic                ext_stall,
   input  logic                flush,
   input  logic                var_done,
   input  logic [REG_W-1:0]    var_done_rd,
   output logic [NUM_REGS-1:0] busy_vec,
   output logic [CNT_W-1:0]    stall_cycles
);
   logic [NUM_REGS-1:0] var_vec;
   logic [REG_W-1:0]    rs_sel;
   logic                src_hazard;
   logic                waw_hazard;
   logic                ready;
   logic                fire;
   logic [CNT_W-1:0]    stall_cycles_q;
   logic [CNT_W-1:0]    stall_cycles_d;

   for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
      if (r == 0) begin : g_x0
         assign busy_vec[r] = 1'b0;
         assign var_vec[r]  = 1'b0;
      end else begin : g_entry
         sb_entry #(.LAT_W(LAT_W)) u_entry (
            .clk     (clk),
            .rst     (rst),
            .set     (fire && iss.issue_rd_write && (iss.issue_rd == REG_W'(r))),
            .set_lat (iss.issue_lat),
            .var_clr (var_done && (var_done_rd == REG_W'(r))),
            .flush   (flush),
            .busy    (busy_vec[r]),
            .is_var  (var_vec[r])
         );
      end
   end

   always_comb begin
      src_hazard = 1'b0;
      rs_sel     = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         rs_sel = iss.issue_rs[i*REG_W +: REG_W];
         if (iss.issue_rs_read[i] && (rs_sel != '0) && busy_vec[rs_sel]) src_hazard = 1'b1;
      end
   end

   // Overwriting a fixed-latency write is safe; a variable one would race its unit.
   assign waw_hazard = iss.issue_rd_write && (iss.issue_rd != '0) &&
                       busy_vec[iss.issue_rd] && var_vec[iss.issue_rd];
   assign ready           = !ext_stall && !src_hazard && !waw_hazard;
   assign fire            = iss.issue_valid && ready;
   assign iss.issue_ready = ready;

   always_comb begin
      stall_cycles_d = stall_cycles_q;
      if (iss.issue_valid && !ready && (stall_cycles_q != '1))
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) stall_cycles_q <= '0;
      else     stall_cycles_q <= stall_cycles_d;
   end

   assign stall_cycles = stall_cycles_q;
endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : tb_hazard_scoreboard
// Brief  : Directed vector table, corner sequences and random run vs a model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;
   localparam int NUM_REGS = 32;
   localparam int NUM_SRC  = 2;
   localparam int MAX_LAT  = 7;
   localparam int REG_W    = 5;
   localparam int LAT_W    = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic                ext_stall, flush, var_done;
   logic [REG_W-1:0]    var_done_rd;
   logic [NUM_REGS-1:0] busy_vec;
   logic [31:0]         stall_cycles;

   logic                sat_ext_stall;
   logic [NUM_REGS-1:0] sat_busy_vec;
   logic [3:0]          sat_stall_cycles;

   hazard_scoreboard_if #(.NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .MAX_LAT(MAX_LAT)) sb_if ();
   hazard_scoreboard_if #(.NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .MAX_LAT(MAX_LAT)) sat_if ();

   hazard_scoreboard #(.NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .MAX_LAT(MAX_LAT), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .iss(sb_if), .ext_stall(ext_stall), .flush(flush),
      .var_done(var_done), .var_done_rd(var_done_rd), .busy_vec(busy_vec),
      .stall_cycles(stall_cycles)
   );

   hazard_scoreboard #(.NUM_REGS(NUM_REGS), .NUM_SRC(NUM_SRC), .MAX_LAT(MAX_LAT), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .iss(sat_if), .ext_stall(sat_ext_stall), .flush(1'b0),
      .var_done(1'b0), .var_done_rd('0), .busy_vec(sat_busy_vec),
      .stall_cycles(sat_stall_cycles)
   );

   typedef struct {
      logic             valid;
      logic [REG_W-1:0] rs0, rs1;
      logic [1:0]       rd_en;
      logic [REG_W-1:0] rd;
      logic             wr;
      logic [LAT_W-1:0] lat;
      logic             xs, fl, vd;
      logic [REG_W-1:0] vrd;
      logic             exp_ready;
      logic [31:0]      exp_busy;
      int               exp_stall;
   } vec_t;

   vec_t vecs[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model: absolute cycle at which each register becomes forwardable.
   longint ready_at[NUM_REGS];
   bit     pend_var[NUM_REGS];
   longint cyc;
   longint m_stall;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic add(input int valid, input int rs0, input int rs1, input int en, input int rd,
                      input int wr, input int lat, input int xs, input int fl, input int vd,
                      input int vrd, input int er, input logic [31:0] eb, input int es);
      vec_t v;
      v.valid = valid[0]; v.rs0 = REG_W'(rs0); v.rs1 = REG_W'(rs1); v.rd_en = en[1:0];
      v.rd = REG_W'(rd); v.wr = wr[0]; v.lat = LAT_W'(lat); v.xs = xs[0]; v.fl = fl[0];
      v.vd = vd[0]; v.vrd = REG_W'(vrd); v.exp_ready = er[0]; v.exp_busy = eb; v.exp_stall = es;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      sb_if.issue_valid    = v.valid;
      sb_if.issue_rs       = {v.rs1, v.rs0};
      sb_if.issue_rs_read  = v.rd_en;
      sb_if.issue_rd       = v.rd;
      sb_if.issue_rd_write = v.wr;
      sb_if.issue_lat      = v.lat;
      ext_stall            = v.xs;
      flush                = v.fl;
      var_done             = v.vd;
      var_done_rd          = v.vrd;
   endtask

   task automatic idle();
      vec_t v;
      v = '{default: '0};
      drive(v);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic bit m_busy(input int r);
      return (r != 0) && (pend_var[r] || (cyc < ready_at[r]));
   endfunction

   task automatic model_reset();
      for (int r = 0; r < NUM_REGS; r++) begin
         ready_at[r] = 0;
         pend_var[r] = 1'b0;
      end
      cyc     = 0;
      m_stall = 0;
   endtask

   task automatic random_run(input int n);
      vec_t          v;
      logic [31:0]   eb;
      bit            hz, er, fire;
      for (int k = 0; k < n; k++) begin
         v       = '{default: '0};
         v.valid = ($urandom_range(0, 3) != 0);
         v.rs0   = REG_W'($urandom_range(0, 7));
         v.rs1   = REG_W'($urandom_range(0, 7));
         v.rd_en = 2'($urandom_range(0, 3));
         v.rd    = REG_W'($urandom_range(0, 7));
         v.wr    = ($urandom_range(0, 3) != 0);
         v.lat   = LAT_W'($urandom_range(0, MAX_LAT));
         v.xs    = ($urandom_range(0, 7) == 0);
         v.fl    = ($urandom_range(0, 15) == 0);
         v.vd    = ($urandom_range(0, 2) == 0);
         v.vrd   = REG_W'($urandom_range(0, 7));
         drive(v);
         #1;
         eb = '0;
         for (int r = 0; r < NUM_REGS; r++) eb[r] = m_busy(r);
         hz = (v.rd_en[0] && m_busy(int'(v.rs0))) || (v.rd_en[1] && m_busy(int'(v.rs1)));
         hz = hz || (v.wr && m_busy(int'(v.rd)) && pend_var[v.rd]);
         er = !v.xs && !hz;
         check("rand_ready", 64'(sb_if.issue_ready), 64'(er));
         check("rand_busy", 64'(busy_vec), 64'(eb));
         check("rand_stall", 64'(stall_cycles), 64'(m_stall));
         fire = v.valid && er;
         if (v.valid && !er && m_stall < 64'hFFFF_FFFF) m_stall++;
         if (v.vd && pend_var[v.vrd]) pend_var[v.vrd] = 1'b0;
         if (v.fl) for (int r = 0; r < NUM_REGS; r++) if (!pend_var[r]) ready_at[r] = 0;
         if (fire && v.wr && v.rd != '0 && !v.fl) begin
            if (v.lat == '0) begin
               pend_var[v.rd] = 1'b1;
               ready_at[v.rd] = 0;
            end else begin
               pend_var[v.rd] = 1'b0;
               ready_at[v.rd] = cyc + 64'(v.lat);
            end
         end
         next_cycle();
         cyc++;
      end
   endtask

   initial begin
      rst = 1'b1;
      idle();
      sat_ext_stall          = 1'b0;
      sat_if.issue_valid     = 1'b0;
      sat_if.issue_rs        = '0;
      sat_if.issue_rs_read   = '0;
      sat_if.issue_rd        = '0;
      sat_if.issue_rd_write  = 1'b0;
      sat_if.issue_lat       = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy_vec), 64'd0);
      check("reset_stall", 64'(stall_cycles), 64'd0);
      check("reset_ready", 64'(sb_if.issue_ready), 64'd1);
      rst = 1'b0;
      next_cycle();

      //  valid rs0 rs1 en rd wr lat xs fl vd vrd  ready busy       stall
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,   0);
      add(1, 0, 0, 0, 3, 1, 2, 0, 0, 0, 0, 1, 32'h0,   0); // fixed RAW producer
      add(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h8,   0);
      add(1, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,   1);
      add(1, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 1, 32'h0,   1); // variable producer
      add(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80,  1);
      add(1, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0, 32'h80,  2); // WAW on var entry
      add(1, 7, 0, 1, 0, 0, 0, 0, 0, 1, 7, 0, 32'h80,  3);
      add(1, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,   4);
      add(1, 0, 0, 0, 4, 1, 5, 0, 0, 0, 0, 1, 32'h0,   4);
      add(1, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 1, 32'h10,  4);
      add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 32'h210, 4); // flush
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h200, 4);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 1, 32'h200, 4);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 32'h200, 4);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,   4);
      add(1, 0, 0, 0, 2, 1, 2, 0, 0, 0, 0, 1, 32'h0,   4);
      add(1, 0, 0, 0, 2, 1, 3, 0, 0, 0, 0, 1, 32'h4,   4); // set beats clear
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4,   4);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4,   4);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,   4);
      add(1, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 1, 32'h0,   4); // latency 1
      add(1, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,   4);
      add(1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 32'h0,   4); // x0 write
      add(1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,   4);
      add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0,   4);
      add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 32'h0,   4);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,   5);
      add(1, 0, 0, 0, 5, 1, 3, 0, 1, 0, 0, 1, 32'h0,   5); // flush drops set
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,   5);
      add(1, 0, 0, 0, 8, 1, 4, 0, 0, 0, 0, 1, 32'h0,   5);
      add(1, 0, 0, 0, 8, 1, 2, 0, 0, 0, 0, 1, 32'h100, 5); // fixed WAW overwrite
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h100, 5);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,   5);
      add(1, 0, 0, 0, 10, 1, 3, 0, 0, 0, 0, 1, 32'h0,  5);
      add(1, 0, 10, 2, 0, 0, 0, 0, 0, 0, 0, 0, 32'h400, 5);
      add(1, 0, 10, 1, 0, 0, 0, 0, 0, 0, 0, 1, 32'h400, 6);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0,   6);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         #1;
         check($sformatf("vec%0d_ready", i), 64'(sb_if.issue_ready), 64'(vecs[i].exp_ready));
         check($sformatf("vec%0d_busy", i), 64'(busy_vec), 64'(vecs[i].exp_busy));
         check($sformatf("vec%0d_stall", i), 64'(stall_cycles), 64'(vecs[i].exp_stall));
         next_cycle();
      end

      // Asynchronous reset with a variable write outstanding.
      vecs.delete();
      add(1, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1, 32'h0, 6);
      drive(vecs[0]);
      next_cycle();
      idle();
      #1;
      check("midrst_pre_busy", 64'(busy_vec), 64'h20);
      rst = 1'b1;
      #1;
      check("midrst_busy", 64'(busy_vec), 64'd0);
      check("midrst_stall", 64'(stall_cycles), 64'd0);
      next_cycle();
      rst = 1'b0;
      #1;
      check("midrst_ready", 64'(sb_if.issue_ready), 64'd1);

      // Saturating stall counter on the narrow-counter instance.
      sat_ext_stall      = 1'b1;
      sat_if.issue_valid = 1'b1;
      repeat (10) next_cycle();
      check("sat_stall_10", 64'(sat_stall_cycles), 64'd10);
      repeat (10) next_cycle();
      check("sat_stall_20", 64'(sat_stall_cycles), 64'd15);
      check("sat_busy", 64'(sat_busy_vec), 64'd0);
      sat_ext_stall      = 1'b0;
      sat_if.issue_valid = 1'b0;

      // Random run from a fresh reset against the reference model.
      idle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      model_reset();
      random_run(600);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
